// File: rtl/trace_pkg.sv
// Shared definitions for the pipeline trace buffer: state encoding, entry width, timestamp width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Optional build macro PIPE_TRACE_TS_EN appends a 32-bit cycle timestamp to every trace entry.
package trace_pkg;

  // Externally visible capture state; the numeric values appear on the state port.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } trace_state_e;

  localparam int TS_W = 32;

`ifdef PIPE_TRACE_TS_EN
  localparam int TS_BITS = TS_W;
`else
  localparam int TS_BITS = 0;
`endif

  // Entry layout is {trig_tag, ch_vld, ch_data[, timestamp]}.
  function automatic int entry_w(input int num_ch, input int ch_w);
    return 1 + num_ch * (ch_w + 1) + TS_BITS;
  endfunction

endpackage

// File: rtl/trace_ram.sv
// Trace storage: DEPTH x WIDTH array with one write port and one registered read port.
// Latency: read data appears one cycle after rd_en; writes land at the clock edge.
// Backpressure: none; every enabled access completes in its cycle.
//
// Ports:
//   clk, rst        clock; rst clears only the read-data register, never the array
//   wr_en/wr_addr/wr_data   write port
//   rd_en/rd_addr           read request; rd_data holds until the next rd_en
//   rd_data                 registered read data
module trace_ram #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 69,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/pipe_trace_buf.sv
// Pipeline trace buffer: records per-channel valid/data every cycle while armed, stops
// POST_CNT samples after a trigger rising edge, then replays the window oldest-first.
// Latency: capture writes in the sample cycle; readout data one cycle after rd_en.
// Backpressure: none; the reader paces readout with rd_en, one entry per cycle.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   arm             pulse; (re)starts a capture from any state
//   trig            trigger level; only its rising edge fires
//   ch_vld, ch_data per-channel valid and data, channel 0 in the MSBs
//   rd_en           readout request while DONE
//   rd_data, rd_vld readout entry and its one-cycle valid pulse
//   state, count    capture state and entries written / still to be read
// Build macro PIPE_TRACE_TS_EN adds a free-running 32-bit timestamp to each entry's LSBs.
module pipe_trace_buf
  import trace_pkg::*;
#(
  parameter  int NUM_CH   = 4,
  parameter  int CH_W     = 16,
  parameter  int DEPTH    = 16,
  parameter  int POST_CNT = 8,
  localparam int ENTRY_W  = entry_w(NUM_CH, CH_W),
  localparam int CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   arm,
  input  logic                   trig,
  input  logic [NUM_CH-1:0]      ch_vld,
  input  logic [NUM_CH*CH_W-1:0] ch_data,
  input  logic                   rd_en,
  output logic [ENTRY_W-1:0]     rd_data,
  output logic                   rd_vld,
  output logic [1:0]             state,
  output logic [CNT_W-1:0]       count
);

  localparam int AW = $clog2(DEPTH);

  trace_state_e     state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             wrapped_q, wrapped_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [AW-1:0]    post_q, post_d;
  logic             trig_q;
  logic             rd_vld_q, rd_vld_d;

  logic               trig_rise;
  logic               capturing;
  logic               wr_en;
  logic               wr_tag;
  logic               last_wr;
  logic               rd_fire;
  logic [AW-1:0]      wr_ptr_inc;
  logic               wrapped_inc;
  logic [CNT_W-1:0]   count_sat;
  logic [ENTRY_W-1:0] wr_entry;

  // trig_q follows trig in every state, so a level already high when armed
  // must drop and rise again before it counts as a trigger.
  assign trig_rise = trig & ~trig_q;

  assign capturing = (state_q == ST_ARMED) || (state_q == ST_POST);
  assign wr_en     = capturing && !arm;
  assign wr_tag    = (state_q == ST_ARMED) && trig_rise;

  // Final write of the window: the trigger sample itself when no post samples
  // are requested, otherwise the post sample taken with the counter at 1.
  assign last_wr = ((state_q == ST_ARMED) && trig_rise && (POST_CNT == 0)) ||
                   ((state_q == ST_POST) && (post_q == AW'(1)));

  assign rd_fire = (state_q == ST_DONE) && rd_en && (count_q != '0) && !arm;

  // Pointer and count values as they stand after this cycle's write.
  assign wr_ptr_inc  = wr_ptr_q + AW'(1);
  assign wrapped_inc = wrapped_q | (wr_ptr_q == AW'(DEPTH - 1));
  assign count_sat   = (count_q == CNT_W'(DEPTH)) ? count_q : count_q + CNT_W'(1);

`ifdef PIPE_TRACE_TS_EN
  logic [TS_W-1:0] ts_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_q + TS_W'(1);
    end
  end

  assign wr_entry = {wr_tag, ch_vld, ch_data, ts_q};
`else
  assign wr_entry = {wr_tag, ch_vld, ch_data};
`endif

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    wrapped_d = wrapped_q;
    count_d   = count_q;
    post_d    = post_q;
    rd_vld_d  = 1'b0;

    if (arm) begin
      // arm wins over trigger and readout in whatever state it arrives.
      state_d   = ST_ARMED;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      wrapped_d = 1'b0;
      count_d   = '0;
      post_d    = '0;
    end else begin
      case (state_q)
        ST_ARMED, ST_POST: begin
          wr_ptr_d  = wr_ptr_inc;
          wrapped_d = wrapped_inc;
          count_d   = count_sat;
          if (state_q == ST_ARMED) begin
            if (trig_rise) begin
              state_d = ST_POST;
              post_d  = AW'(POST_CNT);
            end
          end else begin
            post_d = post_q - AW'(1);
          end
          if (last_wr) begin
            // Once wrapped the oldest entry sits at the next write slot.
            state_d  = ST_DONE;
            rd_ptr_d = wrapped_inc ? wr_ptr_inc : '0;
            count_d  = wrapped_inc ? CNT_W'(DEPTH) : CNT_W'(wr_ptr_inc);
          end
        end
        ST_DONE: begin
          if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            count_d  = count_q - CNT_W'(1);
            rd_vld_d = 1'b1;
            if (count_q == CNT_W'(1)) begin
              state_d = ST_IDLE;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      wrapped_q <= 1'b0;
      count_q   <= '0;
      post_q    <= '0;
      trig_q    <= 1'b0;
      rd_vld_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      wrapped_q <= wrapped_d;
      count_q   <= count_d;
      post_q    <= post_d;
      trig_q    <= trig;
      rd_vld_q  <= rd_vld_d;
    end
  end

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_trace_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_entry),
    .rd_en   (rd_fire),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

  assign rd_vld = rd_vld_q;
  assign state  = state_q;
  assign count  = count_q;

endmodule

// File: tb/tb_pipe_trace_buf.sv
// Directed bench for pipe_trace_buf: a table of capture scenarios replayed in a loop,
// plus hand-written sequences for reset, arm priority and read-data hold.
// Two instances share stimulus: defaults and POST_CNT=0.
module tb_pipe_trace_buf;

`ifdef PIPE_TRACE_TS_EN
  localparam int TSB = 32;
`else
  localparam int TSB = 0;
`endif
  localparam int BODY_W = 69;
  localparam int EW     = BODY_W + TSB;

  logic          clk = 1'b0;
  logic          rst, arm, trig, rd_en;
  logic [3:0]    ch_vld;
  logic [63:0]   ch_data;
  logic [EW-1:0] rd_data0, rd_data1;
  logic          rd_vld0, rd_vld1;
  logic [1:0]    st0, st1;
  logic [4:0]    cnt0, cnt1;

  always #5 clk = ~clk;

  pipe_trace_buf u_dut (
    .clk(clk), .rst(rst), .arm(arm), .trig(trig), .ch_vld(ch_vld), .ch_data(ch_data),
    .rd_en(rd_en), .rd_data(rd_data0), .rd_vld(rd_vld0), .state(st0), .count(cnt0)
  );

  pipe_trace_buf #(.POST_CNT(0)) u_dut_p0 (
    .clk(clk), .rst(rst), .arm(arm), .trig(trig), .ch_vld(ch_vld), .ch_data(ch_data),
    .rd_en(rd_en), .rd_data(rd_data1), .rd_vld(rd_vld1), .state(st1), .count(cnt1)
  );

  int checks = 0;
  int errors = 0;
  int samp   = 0;
  bit sel    = 1'b0;

  logic [1:0]    cur_st;
  logic [4:0]    cur_cnt;
  logic          cur_vld;
  logic [EW-1:0] cur_dat;

  always_comb begin
    cur_st  = sel ? st1 : st0;
    cur_cnt = sel ? cnt1 : cnt0;
    cur_vld = sel ? rd_vld1 : rd_vld0;
    cur_dat = sel ? rd_data1 : rd_data0;
  end

  function automatic logic [63:0] mk_data(input int s);
    logic [63:0] d;
    d = '0;
    for (int i = 0; i < 4; i++) d[(3-i)*16 +: 16] = 16'(s * 4 + i);
    return d;
  endfunction

  function automatic logic [3:0] mk_vld(input int s);
    return 4'(s) ^ 4'b0101;
  endfunction

  function automatic logic [BODY_W-1:0] exp_entry(input int s, input bit tag);
    return {tag, mk_vld(s), mk_data(s)};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock edge carrying sample 'samp'; outputs are sampled 1 time unit later.
  task automatic step();
    ch_data = mk_data(samp);
    ch_vld  = mk_vld(samp);
    @(posedge clk);
    #1;
    samp++;
  endtask

  // Reset, arm, then run until DONE (bounded). Write w carries sample arm_s + w.
  task automatic run_capture(input bit sel_i, input int trig_at, input int pre_hold,
                             output int arm_s, output int edges, output bit done);
    sel   = sel_i;
    rd_en = 1'b0;
    trig  = 1'b0;
    rst   = 1'b1;
    step();
    rst   = 1'b0;
    arm   = 1'b1;
    trig  = (pre_hold > 0);
    arm_s = samp;
    step();
    arm   = 1'b0;
    done  = 1'b0;
    edges = 0;
    for (int w = 1; w <= 200 && !done; w++) begin
      if (w <= pre_hold)     trig = 1'b1;
      else if (w < trig_at)  trig = 1'b0;
      else                   trig = 1'b1;
      step();
      edges = w;
      if (cur_st == 2'd3) done = 1'b1;
    end
    trig = 1'b0;
  endtask

  typedef struct {
    bit sel;        // 0: default instance, 1: POST_CNT=0 instance
    int trig_at;    // write index whose cycle carries the trigger rise
    int pre_hold;   // trig high at arm and for this many writes
    int exp_lat;    // edges from arm to DONE
    int exp_cnt;
    int exp_tag;    // 1-based readout position of the tagged entry
    int exp_first;  // write index of the oldest entry read
  } vec_t;

  vec_t vecs[8];

  initial begin
    int   arm_s, edges;
    bit   done;
    logic [31:0] prev_ts;

    rst = 1'b1; arm = 1'b0; trig = 1'b0; rd_en = 1'b0; ch_vld = '0; ch_data = '0;
    prev_ts = '0;

    vecs[0] = '{0,  4,  0, 12, 12,  4,  1};  // basic window
    vecs[1] = '{0, 21,  0, 29, 16,  8, 14};  // wrapped, oldest-first
    vecs[2] = '{1,  3,  0,  3,  3,  3,  1};  // POST_CNT=0
    vecs[3] = '{0, 13, 10, 21, 16,  8,  6};  // trig held at arm, fires on later rise
    vecs[4] = '{0,  1,  0,  9,  9,  1,  1};  // trigger on first write
    vecs[5] = '{0,  8,  0, 16, 16,  8,  1};  // exactly DEPTH writes
    vecs[6] = '{0,  7,  0, 15, 15,  7,  1};  // one short of full
    vecs[7] = '{1, 20,  0, 20, 16, 16,  5};  // POST_CNT=0 with wrap

    // Reset state
    step();
    chk("rst_state", st0, 2'd0);
    chk("rst_count", cnt0, 5'd0);
    chk("rst_rd_vld", rd_vld0, 1'b0);
    chk("rst_rd_data", rd_data0, '0);
    chk("rst_state_p0", st1, 2'd0);

    for (int v = 0; v < 8; v++) begin
      run_capture(vecs[v].sel, vecs[v].trig_at, vecs[v].pre_hold, arm_s, edges, done);
      chk($sformatf("v%0d_done_lat", v), done ? edges : -1, vecs[v].exp_lat);
      chk($sformatf("v%0d_state", v), cur_st, 2'd3);
      chk($sformatf("v%0d_count", v), cur_cnt, vecs[v].exp_cnt);
      if (done) begin
        for (int k = 0; k < vecs[v].exp_cnt; k++) begin
          rd_en = 1'b1;
          step();
          chk($sformatf("v%0d_rd%0d_vld", v, k), cur_vld, 1'b1);
          chk($sformatf("v%0d_rd%0d_data", v, k), cur_dat[EW-1 -: BODY_W],
              exp_entry(arm_s + vecs[v].exp_first + k, (k + 1) == vecs[v].exp_tag));
          chk($sformatf("v%0d_rd%0d_cnt", v, k), cur_cnt, vecs[v].exp_cnt - k - 1);
`ifdef PIPE_TRACE_TS_EN
          if (k > 0) chk($sformatf("v%0d_rd%0d_ts", v, k), cur_dat[TSB-1:0], prev_ts + 32'd1);
          prev_ts = cur_dat[TSB-1:0];
`endif
        end
        rd_en = 1'b0;
        chk($sformatf("v%0d_idle", v), cur_st, 2'd0);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        chk($sformatf("v%0d_idle_rd_vld", v), cur_vld, 1'b0);
      end
    end
    sel = 1'b0;

    // Reset in the middle of POST
    rst = 1'b1; step(); rst = 1'b0;
    arm = 1'b1; step(); arm = 1'b0;
    trig = 1'b0; step();
    trig = 1'b1; step();
    step(); step(); step();
    chk("midpost_state", st0, 2'd2);
    chk("midpost_count", cnt0, 5'd5);
    rst = 1'b1; step(); rst = 1'b0; trig = 1'b0;
    chk("midpost_rst_state", st0, 2'd0);
    chk("midpost_rst_count", cnt0, 5'd0);
    chk("midpost_rst_vld", rd_vld0, 1'b0);
    rd_en = 1'b1; step(); rd_en = 1'b0;
    chk("midpost_rd_ignored", rd_vld0, 1'b0);

    // rd_data hold, then reset in the middle of readout
    run_capture(1'b0, 2, 0, arm_s, edges, done);
    chk("hold_done", done, 1'b1);
    chk("hold_count", cnt0, 5'd10);
    rd_en = 1'b1; step(); rd_en = 1'b0;
    chk("hold_rd1_vld", rd_vld0, 1'b1);
    chk("hold_rd1_data", rd_data0[EW-1 -: BODY_W], exp_entry(arm_s + 1, 1'b0));
    step();
    chk("hold_gap_vld", rd_vld0, 1'b0);
    chk("hold_gap_data", rd_data0[EW-1 -: BODY_W], exp_entry(arm_s + 1, 1'b0));
    chk("hold_gap_count", cnt0, 5'd9);
    rd_en = 1'b1; rst = 1'b1; step(); rst = 1'b0;
    chk("midrd_rst_state", st0, 2'd0);
    chk("midrd_rst_count", cnt0, 5'd0);
    chk("midrd_rst_vld", rd_vld0, 1'b0);
    chk("midrd_rst_data", rd_data0, '0);
    step(); rd_en = 1'b0;
    chk("midrd_rd_ignored", rd_vld0, 1'b0);

    // arm beats rd_en in DONE, and beats a trigger rise in ARMED
    run_capture(1'b0, 1, 0, arm_s, edges, done);
    chk("prio_done_count", cnt0, 5'd9);
    arm = 1'b1; rd_en = 1'b1; step(); arm = 1'b0; rd_en = 1'b0;
    chk("prio_rd_state", st0, 2'd1);
    chk("prio_rd_count", cnt0, 5'd0);
    chk("prio_rd_vld", rd_vld0, 1'b0);
    step();
    arm = 1'b1; trig = 1'b1; step(); arm = 1'b0;
    chk("prio_trig_state", st0, 2'd1);
    chk("prio_trig_count", cnt0, 5'd0);
    step();
    chk("held_trig_state", st0, 2'd1);
    chk("held_trig_count", cnt0, 5'd1);
    trig = 1'b0; step();
    trig = 1'b1; step();
    chk("rerise_state", st0, 2'd2);
    chk("rerise_count", cnt0, 5'd3);
    trig = 1'b0;
    rst = 1'b1; step(); rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
